// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: state encodings and per-stage control bundles for the stall sequencer
package pipe_stall_ctrl_pkg;
  typedef enum logic [1:0] {
    PSC_RUN     = 2'd0,
    PSC_IC_WAIT = 2'd1,
    PSC_IC_KILL = 2'd2,
    PSC_DC_WAIT = 2'd3
  } psc_state_e;
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
    logic if_id_flush;
    logic id_ex_flush;
  } ctl_t;
  localparam ctl_t CTL_NONE = 7'b00000_00;
  localparam ctl_t CTL_ALL  = 7'b11111_00;
  localparam ctl_t CTL_LU   = 7'b11000_01;
  localparam ctl_t CTL_ICM  = 7'b10000_10;
  localparam ctl_t CTL_BR   = 7'b00000_11;
endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// stall_watchdog: counts consecutive fill-wait cycles and latches a sticky timeout flag
module stall_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic err_timeout
);
  logic [31:0] wait_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      wait_cnt <= clr ? '0 : (inc && wait_cnt != '1) ? wait_cnt + 32'd1 : wait_cnt;
      if (TIMEOUT_CYCLES != 0 && inc && wait_cnt == TIMEOUT_CYCLES - 1) err_timeout <= 1'b1;
    end
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges cache misses, load-use and branch redirects into per-stage stall/flush
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int          CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dc_miss,
  input  logic                 dc_ready,
  input  logic                 ic_miss,
  input  logic                 ic_ready,
  input  logic                 lu_hazard,
  input  logic                 ex_branch_taken,
  output logic                 PC_Stall,
  output logic                 IF_ID_Stall,
  output logic                 ID_EX_Stall,
  output logic                 EX_MEM_Stall,
  output logic                 MEM_WB_Stall,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic                 err_timeout
);
  psc_state_e state, state_nxt, ret_state, ret_nxt, eff;
  ctl_t ctl;
  logic dm;
  // On the D-cache release cycle the saved state is decoded as if it were current
  always_comb begin
    eff       = (state == PSC_DC_WAIT) ? ret_state : state;
    dm        = (state != PSC_DC_WAIT) && dc_miss;
    ctl       = CTL_NONE;
    state_nxt = state;
    ret_nxt   = ret_state;
    if (state == PSC_DC_WAIT && !dc_ready) begin
      ctl = CTL_ALL;
    end else if (dm) begin
      ctl       = CTL_ALL;
      ret_nxt   = eff;
      state_nxt = PSC_DC_WAIT;
    end else begin
      case (eff)
        PSC_RUN: begin
          ctl       = ex_branch_taken ? CTL_BR : lu_hazard ? CTL_LU : ic_miss ? CTL_ICM : CTL_NONE;
          state_nxt = !ic_miss ? PSC_RUN : ex_branch_taken ? PSC_IC_KILL : PSC_IC_WAIT;
        end
        PSC_IC_WAIT: begin
          ctl       = ex_branch_taken ? CTL_BR : lu_hazard ? CTL_LU : ic_ready ? CTL_NONE : CTL_ICM;
          state_nxt = ic_ready ? PSC_RUN : ex_branch_taken ? PSC_IC_KILL : PSC_IC_WAIT;
        end
        default: begin
          ctl       = CTL_ICM;
          state_nxt = ic_ready ? PSC_RUN : PSC_IC_KILL;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PSC_RUN;
      ret_state <= PSC_RUN;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
    end
  end
  assign {PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall, IF_ID_Flush, ID_EX_Flush} =
    rst_n ? ctl : CTL_NONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (PC_Stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end
  stall_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (state_nxt == PSC_RUN),
    .inc         (state != PSC_RUN),
    .err_timeout (err_timeout)
  );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenarios with a queue-based scoreboard checked every cycle
module tb_pipe_stall_ctrl;
  localparam int CW = 4;
  localparam logic [5:0] IDLE = 6'b000000, DM = 6'b100000, DR = 6'b010000, IM = 6'b001000,
                         IR = 6'b000100, LU = 6'b000010, BR = 6'b000001;
  localparam logic [7:0] E_NONE = 8'b11111_00_0 & 8'h00, E_ALL = 8'b11111_00_0,
                         E_LU = 8'b11000_01_0, E_ICM = 8'b10000_10_0, E_BR = 8'b00000_11_0;
  typedef struct {
    string      name;
    logic [7:0] o;
    int         c;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic dc_miss = 0, dc_ready = 0, ic_miss = 0, ic_ready = 0, lu_hazard = 0, ex_branch_taken = 0;
  logic PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall, IF_ID_Flush, ID_EX_Flush;
  logic [CW-1:0] stall_cycles;
  logic err_timeout;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, exp_cnt = 0;

  pipe_stall_ctrl #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .dc_miss(dc_miss), .dc_ready(dc_ready), .ic_miss(ic_miss),
    .ic_ready(ic_ready), .lu_hazard(lu_hazard), .ex_branch_taken(ex_branch_taken),
    .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .ID_EX_Stall(ID_EX_Stall),
    .EX_MEM_Stall(EX_MEM_Stall), .MEM_WB_Stall(MEM_WB_Stall), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .stall_cycles(stall_cycles), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input string n, input logic [5:0] in, input logic [7:0] e);
    @(posedge clk);
    #1;
    {dc_miss, dc_ready, ic_miss, ic_ready, lu_hazard, ex_branch_taken} = in;
    q.push_back('{n, e, exp_cnt});
    if (e[7] && exp_cnt < (1 << CW) - 1) exp_cnt++;
  endtask

  task automatic do_reset(input string n);
    @(posedge clk);
    #1;
    rst_n = 0;
    {dc_miss, dc_ready, ic_miss, ic_ready, lu_hazard, ex_branch_taken} = 6'b101011;
    exp_cnt = 0;
    q.push_back('{n, 8'h00, 0});
    @(posedge clk);
    #1;
    rst_n = 1;
    {dc_miss, dc_ready, ic_miss, ic_ready, lu_hazard, ex_branch_taken} = IDLE;
  endtask

  // Monitor: the DUT presents a fresh control word every cycle
  always @(negedge clk) begin
    exp_t x;
    logic [7:0] got;
    if (q.size() != 0) begin
      x = q.pop_front();
      got = {PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall, IF_ID_Flush, ID_EX_Flush, err_timeout};
      n_cmp++;
      if (got !== x.o) begin
        n_bad++;
        $display("FAIL %s ctl: got %b want %b", x.name, got, x.o);
      end
      n_cmp++;
      if (stall_cycles !== CW'(x.c)) begin
        n_bad++;
        $display("FAIL %s stall_cycles: got %0d want %0d", x.name, stall_cycles, x.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset("t1_rst");
    step("t1_lu", LU, E_LU);
    step("t1_run", IDLE, E_NONE);

    do_reset("t2_rst");
    step("t2_miss", DM, E_ALL);
    repeat (5) step("t2_wait", IDLE, E_ALL);
    step("t2_rel", DR, E_NONE);
    step("t2_after", IDLE, E_NONE);

    do_reset("t3_rst");
    step("t3_im", IM, E_ICM);
    step("t3_wait", IDLE, E_ICM);
    step("t3_br", BR, E_BR);
    step("t3_kill", IDLE, E_ICM);
    step("t3_kill", IDLE, E_ICM);
    step("t3_kill_rdy", IR, E_ICM);
    step("t3_run", IDLE, E_NONE);

    do_reset("t4_rst");
    step("t4_im", IM, E_ICM);
    step("t4_dm", DM, E_ALL);
    repeat (3) step("t4_dwait_ir", IR, E_ALL);
    step("t4_rel", DR | IR, E_NONE);
    step("t4_run", IDLE, E_NONE);

    do_reset("t5_rst");
    step("t5_dm_br", DM | BR, E_ALL);
    repeat (2) step("t5_dwait", DM | BR, E_ALL);
    step("t5_rel", DM | DR | BR, E_BR);
    step("t5_run", IDLE, E_NONE);

    do_reset("t7_rst");
    step("t7_im", IM, E_ICM);
    step("t7_wait_lu", LU, E_LU);
    step("t7_rdy_lu", LU | IR, E_LU);
    step("t7_run", IDLE, E_NONE);

    do_reset("t6_rst");
    step("t6_im", IM, E_ICM);
    repeat (8) step("t6_wait", IDLE, E_ICM);
    repeat (9) step("t6_tmo", IDLE, E_ICM | 8'h01);
    step("t6_rdy", IR, E_NONE | 8'h01);
    step("t6_sticky", IDLE, 8'h01);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
